// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath (Moore style).
// Sequences fetch/decode/execute through the synchronous-read memory and
// drives every datapath control line combinationally from the current state.
module multicycle_control #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic [3:0]       state,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_cnt
);
    typedef enum logic [3:0] {
        F0  = 4'd0,  F1  = 4'd1,  ID  = 4'd2,  MA  = 4'd3,
        MR  = 4'd4,  MWT = 4'd5,  MWB = 4'd6,  MWR = 4'd7,
        EX  = 4'd8,  RWB = 4'd9,  BR  = 4'd10, JMP = 4'd11,
        AIE = 4'd12, AIW = 4'd13
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    state_t cur, nxt;
    logic   op_ok;
    logic   retire;

    assign state = cur;

    // Opcodes this controller knows how to sequence.
    assign op_ok = (opcode == OP_R) || (opcode == OP_LW) || (opcode == OP_SW) ||
                   (opcode == OP_BEQ) || (opcode == OP_J) || (opcode == OP_ADDI);

    // Leaving any final state of a real instruction retires it.
    assign retire = (cur == MWB) || (cur == MWR) || (cur == RWB) ||
                    (cur == BR)  || (cur == JMP) || (cur == AIW);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) cur <= F0;
        else     cur <= nxt;
    end

    // Next-state: opcode matters only in ID (dispatch) and MA (lw vs sw).
    always_comb begin
        nxt = F0;
        case (cur)
            F0:  nxt = F1;
            F1:  nxt = ID;
            ID: begin
                case (opcode)
                    OP_R:         nxt = EX;
                    OP_LW, OP_SW: nxt = MA;
                    OP_BEQ:       nxt = BR;
                    OP_J:         nxt = JMP;
                    OP_ADDI:      nxt = AIE;
                    default:      nxt = F0;
                endcase
            end
            MA:      nxt = (opcode == OP_LW) ? MR : MWR;
            MR:      nxt = MWT;
            MWT:     nxt = MWB;
            EX:      nxt = RWB;
            AIE:     nxt = AIW;
            default: nxt = F0;  // final states and unused codes 14-15
        endcase
    end

    // Control outputs decoded from state; write enables held off during reset.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        case (cur)
            F0: begin MemRead = 1'b1; ALUSrcB = 2'b01; end
            F1: begin
                MemRead = 1'b1; IRWrite = 1'b1; PCWrite = 1'b1; ALUSrcB = 2'b01;
            end
            ID:      ALUSrcB = 2'b11;
            MA, AIE: begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; end
            MR, MWT: begin MemRead = 1'b1; IorD = 1'b1; end
            MWB:     begin RegWrite = 1'b1; MemtoReg = 1'b1; end
            MWR:     begin MemWrite = 1'b1; IorD = 1'b1; end
            EX:      begin ALUSrcA = 1'b1; ALUOp = 2'b10; end
            RWB:     begin RegWrite = 1'b1; RegDst = 1'b1; end
            BR: begin
                ALUSrcA = 1'b1; ALUOp = 2'b01; PCWriteCond = 1'b1; PCSource = 2'b01;
            end
            JMP:     begin PCWrite = 1'b1; PCSource = 2'b10; end
            AIW:     RegWrite = 1'b1;
            default: ;
        endcase
        if (rst) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            MemWrite    = 1'b0;
            IRWrite     = 1'b0;
            RegWrite    = 1'b0;
        end
    end

    // Flag an unsupported opcode during the F0 that follows its ID.
    always_ff @(posedge clk) begin
        if (rst) illegal <= 1'b0;
        else     illegal <= (cur == ID) && !op_ok;
    end

    // Retired-instruction counter, wraps naturally.
    always_ff @(posedge clk) begin
        if (rst)         instr_cnt <= '0;
        else if (retire) instr_cnt <= instr_cnt + 1'b1;
    end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style main control FSM for the multicycle MIPS datapath.
- Sits directly upstream of the memory/IR stage and drives its MemRead, MemWrite, IorD and IRWrite inputs.
- Also drives the PC, register-file and ALU-operand mux controls.
- Decodes IR[31:26] once per instruction; sequencing accounts for the synchronous-read RAM (read data valid one cycle after the address).

Parameters:
CNT_W, 32, width of retired-instruction counter

Ports:
clk  input  1  system clock, all state updates on posedge
rst  input  1  synchronous active-high reset
opcode  input  6  IR[31:26] from memory stage IR register
PCWrite  output  1  unconditional PC load
PCWriteCond  output  1  PC load qualified by ALU zero (beq)
IorD  output  1  memory address select: 0=PC, 1=ALUOut
MemRead  output  1  memory read enable
MemWrite  output  1  memory write enable
IRWrite  output  1  IR capture enable
MemtoReg  output  1  regfile write data: 0=ALUOut, 1=MDR
RegDst  output  1  regfile dest: 0=rt, 1=rd
RegWrite  output  1  regfile write enable
ALUSrcA  output  1  0=PC, 1=reg A
ALUSrcB  output  2  00=reg B, 01=const 4, 10=signext imm, 11=signext imm<<2
ALUOp  output  2  00=add, 01=sub, 10=funct-decoded
PCSource  output  2  00=ALU result, 01=ALUOut, 10=jump target
state  output  4  current state encoding (debug)
illegal  output  1  one-cycle pulse on unsupported opcode
instr_cnt  output  CNT_W  retired-instruction count

Behaviour:
- State encodings: F0=0, F1=1, ID=2, MA=3, MR=4, MWT=5, MWB=6, MWR=7, EX=8, RWB=9, BR=10, JMP=11, AIE=12, AIW=13. Codes 14-15 go to F0 on the next edge.
- All control outputs are combinational from state. Any output not listed for a state is 0.
  - F0: MemRead=1, IorD=0, ALUSrcB=01. Issues the fetch address.
  - F1: MemRead=1, IorD=0, IRWrite=1, PCWrite=1, PCSource=00, ALUSrcB=01. IR and PC+4 load at the end of F1.
  - ID: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Branch target goes to ALUOut.
  - MA: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - MR and MWT: MemRead=1, IorD=1. MDR is valid at the end of MWT.
  - MWB: RegWrite=1, MemtoReg=1, RegDst=0.
  - MWR: MemWrite=1, IorD=1.
  - EX: ALUSrcA=1, ALUSrcB=00, ALUOp=10.
  - RWB: RegWrite=1, RegDst=1, MemtoReg=0.
  - BR: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01.
  - JMP: PCWrite=1, PCSource=10.
  - AIE: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - AIW: RegWrite=1, RegDst=0, MemtoReg=0.
- Transitions:
  - F0→F1→ID.
  - ID dispatches on opcode, sampled only in ID:
    - 000000 (R-type) → EX
    - 100011 (lw) / 101011 (sw) → MA
    - 000100 (beq) → BR
    - 000010 (j) → JMP
    - 001000 (addi) → AIE
    - anything else → F0
  - MA→MR if opcode=lw, else →MWR.
  - MR→MWT→MWB→F0.
  - EX→RWB→F0.
  - AIE→AIW→F0.
  - MWR, BR, JMP → F0.
- Latency in cycles, counted from F0 entry to return to F0: R=5, lw=7, sw=5, beq=4, j=4, addi=5, illegal=3.
- illegal: registered. It is 1 for exactly the cycle after ID when the opcode is unsupported (i.e. during that F0).
- instr_cnt increments by 1 (wraps mod 2^CNT_W) on each transition out of MWB, MWR, RWB, BR, JMP or AIW. Illegal opcodes do not count.
- Reset:
  - rst=1 at a posedge → state=F0, instr_cnt=0, illegal=0.
  - While rst=1, PCWrite, PCWriteCond, MemWrite, IRWrite and RegWrite are forced to 0 combinationally.
  - Reset mid-instruction abandons it; no count is taken.
- After reset release, the first cycle is F0 with MemRead=1, IorD=0, ALUSrcB=01.
- The opcode input is ignored outside ID and MA.

Test Plan:
- Reset: hold rst 3 cycles in arbitrary state → state=0, instr_cnt=0, all write enables 0 during rst; first post-reset cycle MemRead=1, IorD=0.
- R-type: opcode=000000 → state sequence 0,1,2,8,9,0; RegWrite=1 & RegDst=1 only in state 9; instr_cnt=1.
- lw then sw: opcode=100011, then 101011 → states 0,1,2,3,4,5,6,0 then 0,1,2,3,7,0; MemWrite=1 with IorD=1 exactly one cycle; instr_cnt=2.
- beq, j, addi back-to-back → 4, 4, 5 cycles respectively; PCWriteCond only in BR; PCSource=10 only in JMP; instr_cnt=3.
- Illegal opcode 111111 → 0,1,2,0; illegal=1 for one cycle; instr_cnt unchanged.
- rst asserted during MWT of lw → next state 0, RegWrite never asserted for that lw, instr_cnt=0. Opcode toggled outside ID → sequence unaffected.
